// File: rtl/cs_bus_gate.sv
// Gates host bus strobes into the write/read FIFOs while the chip-select stage selects the block.
// Optional per-direction transfer counters are enabled by defining BUS_XFER_COUNT_EN.
module cs_bus_gate #(
  parameter int DATA_W = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic              OUT_Z,
  input  logic [DATA_W-1:0] BUS_DIN,
  input  logic              BUS_WR,
  input  logic              BUS_RD,
  output logic [DATA_W-1:0] BUS_DOUT,
  output logic              BUS_OE,
  output logic              BUS_FULL,
  output logic              BUS_EMPTY,
  output logic [DATA_W-1:0] WR_DATA,
  output logic              WR_EN,
  input  logic              WR_FULL,
  input  logic [DATA_W-1:0] RD_DATA,
  output logic              RD_EN,
  input  logic              RD_EMPTY,
  output logic [2:0]        ERR,
  output logic [15:0]       WR_CNT,
  output logic [15:0]       RD_CNT
);

  typedef enum logic [1:0] {IDLE, SETTLE, ACTIVE, DRAIN} state_t;

  state_t            r_state;
  logic              r_oe;
  logic              r_wr_en_p1;
  logic [DATA_W-1:0] r_wr_data_p1;
  logic [DATA_W-1:0] r_dout_p1;
  logic              r_full;
  logic              r_empty;
  logic [2:0]        r_err;

  logic w_sel;
  logic w_wr_req;
  logic w_rd_req;
  logic w_wr_ok;
  logic w_rd_ok;

  // A strobe pair is a host protocol error, so neither side is accepted.
  assign w_sel    = (r_state == ACTIVE) && CS;
  assign w_wr_req = w_sel && BUS_WR && !BUS_RD;
  assign w_rd_req = w_sel && BUS_RD && !BUS_WR;
  assign w_wr_ok  = w_wr_req && !WR_FULL;
  assign w_rd_ok  = w_rd_req && !RD_EMPTY && !RST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= IDLE;
      r_oe    <= 1'b0;
    end else begin
      r_oe <= 1'b0;
      case (r_state)
        IDLE:   if (CS) r_state <= SETTLE;
        SETTLE: begin
          if (CS) begin
            r_state <= ACTIVE;
            r_oe    <= !OUT_Z;
          end else begin
            r_state <= IDLE;
          end
        end
        ACTIVE: begin
          if (CS) r_oe <= !OUT_Z;
          else    r_state <= DRAIN;
        end
        DRAIN: begin
          if (CS)         r_state <= SETTLE;
          else if (OUT_Z) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Stage p0 -> p1: strobe cycle to registered FIFO/bus outputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_en_p1   <= 1'b0;
      r_wr_data_p1 <= '0;
      r_dout_p1    <= '0;
      r_full       <= 1'b0;
      r_empty      <= 1'b1;
      r_err        <= 3'b000;
    end else begin
      r_wr_en_p1 <= w_wr_ok;
      if (w_wr_ok) r_wr_data_p1 <= BUS_DIN;
      if (w_rd_ok) r_dout_p1 <= RD_DATA;
      r_full  <= WR_FULL;
      r_empty <= RD_EMPTY;
      r_err   <= r_err | {w_sel && BUS_WR && BUS_RD,
                          w_rd_req && RD_EMPTY,
                          w_wr_req && WR_FULL};
    end
  end

`ifdef BUS_XFER_COUNT_EN
  logic [15:0] r_wr_cnt;
  logic [15:0] r_rd_cnt;

  // Counted on acceptance so the count tracks WR_EN and never includes a reset-discarded word.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_wr_cnt <= 16'd0;
      r_rd_cnt <= 16'd0;
    end else begin
      if (w_wr_ok) r_wr_cnt <= r_wr_cnt + 16'd1;
      if (w_rd_ok) r_rd_cnt <= r_rd_cnt + 16'd1;
    end
  end

  assign WR_CNT = r_wr_cnt;
  assign RD_CNT = r_rd_cnt;
`else
  assign WR_CNT = 16'd0;
  assign RD_CNT = 16'd0;
`endif

  assign RD_EN     = w_rd_ok;
  assign WR_EN     = r_wr_en_p1;
  assign WR_DATA   = r_wr_data_p1;
  assign BUS_DOUT  = r_dout_p1;
  assign BUS_OE    = r_oe;
  assign BUS_FULL  = r_full;
  assign BUS_EMPTY = r_empty;
  assign ERR       = r_err;

endmodule

// File: tb/tb_cs_bus_gate.sv
// Scoreboard bench for cs_bus_gate: directed stimulus pushes expected words, a negedge monitor pops them.
module tb_cs_bus_gate;

  logic        CLK = 1'b0;
  logic        RST, CS, OUT_Z, BUS_WR, BUS_RD, WR_FULL, RD_EMPTY;
  logic [15:0] BUS_DIN, RD_DATA;
  logic [15:0] BUS_DOUT, WR_DATA, WR_CNT, RD_CNT;
  logic        BUS_OE, BUS_FULL, BUS_EMPTY, WR_EN, RD_EN;
  logic [2:0]  ERR;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] wr_q[$];
  logic [15:0] rd_q[$];
  logic [15:0] rd_exp;
  logic        rd_pending = 1'b0;

  cs_bus_gate dut (
    .CLK(CLK), .RST(RST), .CS(CS), .OUT_Z(OUT_Z),
    .BUS_DIN(BUS_DIN), .BUS_WR(BUS_WR), .BUS_RD(BUS_RD),
    .BUS_DOUT(BUS_DOUT), .BUS_OE(BUS_OE), .BUS_FULL(BUS_FULL), .BUS_EMPTY(BUS_EMPTY),
    .WR_DATA(WR_DATA), .WR_EN(WR_EN), .WR_FULL(WR_FULL),
    .RD_DATA(RD_DATA), .RD_EN(RD_EN), .RD_EMPTY(RD_EMPTY),
    .ERR(ERR), .WR_CNT(WR_CNT), .RD_CNT(RD_CNT)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Monitor: every WR_EN pulse must match the oldest pushed write; every RD_EN must show its word next cycle.
  always @(negedge CLK) begin
    if (rd_pending) begin
      chk("rd_bus_dout", {16'd0, BUS_DOUT}, {16'd0, rd_exp});
      rd_pending = 1'b0;
    end
    if (WR_EN === 1'b1) begin
      if (wr_q.size() == 0) chk("wr_unexpected_pulse", 32'd1, 32'd0);
      else chk("wr_data", {16'd0, WR_DATA}, {16'd0, wr_q.pop_front()});
    end
    if (RD_EN === 1'b1) begin
      if (rd_q.size() == 0) chk("rd_unexpected_pulse", 32'd1, 32'd0);
      else begin
        rd_exp     = rd_q.pop_front();
        rd_pending = 1'b1;
      end
    end
  end

  initial begin
    RST = 1'b1; CS = 1'b0; OUT_Z = 1'b0; BUS_WR = 1'b0; BUS_RD = 1'b0;
    WR_FULL = 1'b0; RD_EMPTY = 1'b1; BUS_DIN = 16'h0; RD_DATA = 16'h0;
    tick(); tick();
    chk("rst_bus_oe", {31'd0, BUS_OE}, 32'd0);
    chk("rst_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("rst_rd_en", {31'd0, RD_EN}, 32'd0);
    chk("rst_wr_data", {16'd0, WR_DATA}, 32'd0);
    chk("rst_bus_dout", {16'd0, BUS_DOUT}, 32'd0);
    chk("rst_bus_full", {31'd0, BUS_FULL}, 32'd0);
    chk("rst_bus_empty", {31'd0, BUS_EMPTY}, 32'd1);
    chk("rst_err", {29'd0, ERR}, 32'd0);
    chk("rst_wr_cnt", {16'd0, WR_CNT}, 32'd0);
    RST = 1'b0;

    // Strobes while deselected are ignored and raise no error.
    BUS_WR = 1'b1; BUS_RD = 1'b1; WR_FULL = 1'b1; BUS_DIN = 16'h1111;
    tick();
    BUS_WR = 1'b0; BUS_RD = 1'b0; WR_FULL = 1'b0;
    chk("idle_ignore_err", {29'd0, ERR}, 32'd0);

    // Strobe during SETTLE is also ignored.
    CS = 1'b1;
    tick();
    BUS_WR = 1'b1; BUS_DIN = 16'h2222;
    tick();
    BUS_WR = 1'b0;
    chk("settle_ignore_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("active_bus_oe", {31'd0, BUS_OE}, 32'd1);

    BUS_WR = 1'b1; BUS_DIN = 16'hA5A5; wr_q.push_back(16'hA5A5);
    tick();
    BUS_WR = 1'b0;
    chk("wr_en_pulse", {31'd0, WR_EN}, 32'd1);
    chk("wr_data_a5a5", {16'd0, WR_DATA}, 32'h0000A5A5);
`ifdef BUS_XFER_COUNT_EN
    chk("wr_cnt_one", {16'd0, WR_CNT}, 32'd1);
`else
    chk("wr_cnt_tied", {16'd0, WR_CNT}, 32'd0);
`endif

    RD_DATA = 16'h1234; RD_EMPTY = 1'b0; BUS_RD = 1'b1; rd_q.push_back(16'h1234);
    #1;
    chk("rd_en_comb", {31'd0, RD_EN}, 32'd1);
    tick();
    BUS_RD = 1'b0; RD_DATA = 16'h5678;
    chk("rd_bus_oe", {31'd0, BUS_OE}, 32'd1);
    chk("bus_empty_copy", {31'd0, BUS_EMPTY}, 32'd0);
    tick();
    chk("bus_dout_hold", {16'd0, BUS_DOUT}, 32'h00001234);

    WR_FULL = 1'b1; BUS_WR = 1'b1; BUS_DIN = 16'hDEAD;
    tick();
    BUS_WR = 1'b0;
    chk("full_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("full_err", {29'd0, ERR}, 32'd1);
    chk("bus_full_copy", {31'd0, BUS_FULL}, 32'd1);
    WR_FULL = 1'b0;
    tick();
    chk("bus_full_clear", {31'd0, BUS_FULL}, 32'd0);

    RD_EMPTY = 1'b1; RD_DATA = 16'h9999; BUS_RD = 1'b1;
    #1;
    chk("empty_rd_en", {31'd0, RD_EN}, 32'd0);
    tick();
    BUS_RD = 1'b0;
    chk("empty_dout_hold", {16'd0, BUS_DOUT}, 32'h00001234);
    chk("empty_err", {29'd0, ERR}, 32'd3);

    RD_EMPTY = 1'b0; RD_DATA = 16'h4321; BUS_WR = 1'b1; BUS_RD = 1'b1; BUS_DIN = 16'hBEEF;
    #1;
    chk("both_rd_en", {31'd0, RD_EN}, 32'd0);
    tick();
    BUS_WR = 1'b0; BUS_RD = 1'b0;
    chk("both_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("both_err", {29'd0, ERR}, 32'd7);
    chk("both_dout_hold", {16'd0, BUS_DOUT}, 32'h00001234);

    // Last word before deselect drains through WR_EN exactly once.
    BUS_WR = 1'b1; BUS_DIN = 16'h0F0F; wr_q.push_back(16'h0F0F);
    tick();
    BUS_WR = 1'b0; CS = 1'b0;
    chk("drain_wr_en", {31'd0, WR_EN}, 32'd1);
    tick();
    chk("drain_bus_oe", {31'd0, BUS_OE}, 32'd0);
    chk("drain_wr_en_done", {31'd0, WR_EN}, 32'd0);
    tick();
    chk("drain_hold_oe", {31'd0, BUS_OE}, 32'd0);
    OUT_Z = 1'b1;
    tick();
    chk("err_sticky", {29'd0, ERR}, 32'd7);

    CS = 1'b1;
    tick(); tick();
    chk("outz_gates_oe", {31'd0, BUS_OE}, 32'd0);
    OUT_Z = 1'b0;
    tick();
    chk("oe_after_outz", {31'd0, BUS_OE}, 32'd1);
`ifdef BUS_XFER_COUNT_EN
    chk("wr_cnt_two", {16'd0, WR_CNT}, 32'd2);
    chk("rd_cnt_one", {16'd0, RD_CNT}, 32'd1);
`else
    chk("rd_cnt_tied", {16'd0, RD_CNT}, 32'd0);
`endif

    // Reset while a read and a write are offered.
    RST = 1'b1; BUS_RD = 1'b1; RD_EMPTY = 1'b0;
    #1;
    chk("rst_rd_en_block", {31'd0, RD_EN}, 32'd0);
    BUS_RD = 1'b0; BUS_WR = 1'b1; BUS_DIN = 16'h7777;
    tick();
    BUS_WR = 1'b0; RST = 1'b0;
    chk("rst_mid_wr_en", {31'd0, WR_EN}, 32'd0);
    chk("rst_mid_err", {29'd0, ERR}, 32'd0);
    chk("rst_mid_oe", {31'd0, BUS_OE}, 32'd0);
    chk("rst_mid_wr_data", {16'd0, WR_DATA}, 32'd0);
    chk("rst_mid_dout", {16'd0, BUS_DOUT}, 32'd0);
    chk("rst_mid_wr_cnt", {16'd0, WR_CNT}, 32'd0);
    tick();
    chk("rst_mid_no_pulse", {31'd0, WR_EN}, 32'd0);

`ifdef BUS_XFER_COUNT_EN
    tick();
    BUS_WR = 1'b1;
    for (int i = 0; i < 65536; i++) begin
      BUS_DIN = 16'(i);
      wr_q.push_back(16'(i));
      tick();
      if (i == 65534) chk("wr_cnt_ffff", {16'd0, WR_CNT}, 32'h0000FFFF);
    end
    BUS_WR = 1'b0;
    chk("wr_cnt_wrap", {16'd0, WR_CNT}, 32'd0);
`endif

    CS = 1'b0;
    tick(); tick();
    chk("wr_q_drained", wr_q.size(), 32'd0);
    chk("rd_q_drained", rd_q.size(), 32'd0);
    chk("rd_not_pending", {31'd0, rd_pending}, 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
